pll_lock_monitor: RTL

PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

---
 rtl/pll_mon_pkg.sv | 20 ++
 rtl/lock_sync.sv | 24 ++
 rtl/pll_lock_monitor.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pll_mon_pkg.sv
// Shared types and constants for the PLL lock monitor.
// Loss counting is built only when PLL_LOCK_MON_LOSS_CNT_EN is defined.
package pll_mon_pkg;

  localparam int LOSS_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_QUALIFY   = 3'd1,
    ST_HOLD_RST  = 3'd2,
    ST_RUN       = 3'd3,
    ST_LOST      = 3'd4
  } pll_mon_state_t;

  // Counter width able to reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lock_sync.sv
// Multi-flop synchronizer bringing the raw PLL lock into the pixel clock domain.
// Part of pll_lock_monitor; PLL_LOCK_MON_LOSS_CNT_EN has no effect here.
module lock_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d};
    end
  end

  assign q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_monitor.sv
// Qualifies PLL lock, then releases the video pipeline reset and tracks lock losses.
// Define PLL_LOCK_MON_LOSS_CNT_EN to build the saturating loss counter.
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int STABLE_CYCLES   = 1024,
  parameter int RST_HOLD_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lock,
  input  logic                  clr,
  output logic                  vid_rst_n,
  output logic                  locked_stable,
  output logic                  lost_flag,
  output logic [LOSS_CNT_W-1:0] loss_cnt
);

  localparam int QW = cnt_width(STABLE_CYCLES);
  localparam int HW = cnt_width(RST_HOLD_CYCLES);
  localparam logic [QW-1:0] QUAL_LAST = QW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
  localparam logic [QW-1:0] QUAL_ONE  = QW'(1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  logic           w_lock_s;
  logic           w_loss_event;
  pll_mon_state_t r_state;
  logic [QW-1:0]  r_qual_cnt;
  logic [HW-1:0]  r_hold_cnt;
  logic           r_vid_rst_n;
  logic           r_locked_stable;
  logic           r_lost_flag;

  lock_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (lock),
    .q     (w_lock_s)
  );

  // A loss is only ever a drop out of RUN; drops during qualification just restart it.
  assign w_loss_event = (r_state == ST_RUN) && !w_lock_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_WAIT_LOCK;
      r_qual_cnt      <= '0;
      r_hold_cnt      <= '0;
      r_vid_rst_n     <= 1'b0;
      r_locked_stable <= 1'b0;
      r_lost_flag     <= 1'b0;
    end else begin
      r_vid_rst_n     <= 1'b0;
      r_locked_stable <= 1'b0;
      if (clr) begin
        r_lost_flag <= 1'b0;
      end
      case (r_state)
        ST_WAIT_LOCK: begin
          r_qual_cnt <= '0;
          r_hold_cnt <= '0;
          if (w_lock_s) begin
            r_state <= ST_QUALIFY;
          end
        end
        ST_QUALIFY: begin
          if (!w_lock_s) begin
            r_state    <= ST_WAIT_LOCK;
            r_qual_cnt <= '0;
          end else if (r_qual_cnt == QUAL_LAST) begin
            r_state    <= ST_HOLD_RST;
            r_qual_cnt <= '0;
            r_hold_cnt <= '0;
          end else begin
            r_qual_cnt <= r_qual_cnt + QUAL_ONE;
          end
        end
        ST_HOLD_RST: begin
          if (!w_lock_s) begin
            r_state    <= ST_WAIT_LOCK;
            r_hold_cnt <= '0;
          end else if (r_hold_cnt == HOLD_LAST) begin
            r_state         <= ST_RUN;
            r_hold_cnt      <= '0;
            r_vid_rst_n     <= 1'b1;
            r_locked_stable <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_ONE;
          end
        end
        ST_RUN: begin
          if (w_loss_event) begin
            r_state     <= ST_LOST;
            r_lost_flag <= 1'b1;
          end else begin
            r_vid_rst_n     <= 1'b1;
            r_locked_stable <= 1'b1;
          end
        end
        ST_LOST: begin
          r_state <= ST_WAIT_LOCK;
        end
        default: begin
          r_state    <= ST_WAIT_LOCK;
          r_qual_cnt <= '0;
          r_hold_cnt <= '0;
        end
      endcase
    end
  end

  assign vid_rst_n     = r_vid_rst_n;
  assign locked_stable = r_locked_stable;
  assign lost_flag     = r_lost_flag;

`ifdef PLL_LOCK_MON_LOSS_CNT_EN
  localparam logic [LOSS_CNT_W-1:0] LOSS_MAX = '1;
  localparam logic [LOSS_CNT_W-1:0] LOSS_ONE = LOSS_CNT_W'(1);

  logic [LOSS_CNT_W-1:0] r_loss_cnt;

  // A loss on the same edge as clr restarts the count at one rather than zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_loss_cnt <= '0;
    end else if (w_loss_event && clr) begin
      r_loss_cnt <= LOSS_ONE;
    end else if (clr) begin
      r_loss_cnt <= '0;
    end else if (w_loss_event && (r_loss_cnt != LOSS_MAX)) begin
      r_loss_cnt <= r_loss_cnt + LOSS_ONE;
    end
  end

  assign loss_cnt = r_loss_cnt;
`else
  assign loss_cnt = '0;
`endif

endmodule
